// File: rtl/reset_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
// The state codes are visible on the seq_state output, so their encoding is fixed.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      FILTER  = 2'd1,
      STAGGER = 2'd2,
      RUN     = 2'd3
   } seq_state_t;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_CS_FILTER      = 3;
   localparam int DEF_NUM_DOMAINS    = 4;
   localparam int DEF_STAGGER_CYCLES = 8;
   localparam int DEF_NUM_PINS       = 34;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Pin-side bundle of the reset sequencer: per-domain resets, status and GPIO gating.
// The master side is the sequencer; the slave side is the wrapper and design blocks.
interface reset_sequencer_if
   import reset_seq_pkg::*;
#(
   parameter int NUM_PINS    = DEF_NUM_PINS,
   parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);
   logic [NUM_PINS-1:0]    core_out;
   logic [NUM_PINS-1:0]    core_oeb;
   logic [NUM_PINS-1:0]    gpio_out;
   logic [NUM_PINS-1:0]    gpio_oeb;
   logic [NUM_DOMAINS-1:0] domain_nrst;
   logic                   ready;
   seq_state_t             seq_state;

   modport master (
      input  core_out, core_oeb,
      output domain_nrst, gpio_out, gpio_oeb, ready, seq_state
   );

   modport slave (
      output core_out, core_oeb,
      input  domain_nrst, gpio_out, gpio_oeb, ready, seq_state
   );
endinterface

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-release reset synchroniser of STAGES flops.
module reset_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic arst_n,
   output logic sync_nrst
);
   logic [STAGES-1:0] sync_pipe;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) sync_pipe <= '0;
      else         sync_pipe <= {sync_pipe[STAGES-2:0], 1'b1};
   end

   assign sync_nrst = sync_pipe[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Gates the board reset with chip select, synchronises it and releases the block
// resets one domain at a time; GPIOs are held safe until every domain is out of reset.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int CS_FILTER      = DEF_CS_FILTER,
   parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
   parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
   parameter int NUM_PINS       = DEF_NUM_PINS
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               ncs,
   reset_sequencer_if.master  bus
);
   localparam int CW = $clog2(max2(CS_FILTER, STAGGER_CYCLES) + 1);
   localparam int IW = max2(1, $clog2(NUM_DOMAINS));

   localparam logic [CW-1:0] FILT_LAST = CW'(CS_FILTER - 1);
   localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
   localparam logic [IW:0]   LAST_DOM  = (IW + 1)'(NUM_DOMAINS - 1);

   logic                   gated_nrst;
   logic                   sync_nrst;
   seq_state_t             state;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [IW:0]            idx_nxt;
   logic [NUM_DOMAINS-1:0] dom_nrst;
   logic [NUM_DOMAINS:0]   dom_shift;
   logic                   ready_q;

   assign gated_nrst = nrst & ~ncs;

   reset_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .arst_n    (gated_nrst),
      .sync_nrst (sync_nrst)
   );

   // Domains release in index order, so the released set is always a
   // thermometer code; shifting in a one releases exactly domain idx+1.
   assign dom_shift = {dom_nrst, 1'b1};
   assign idx_nxt   = {1'b0, idx} + (IW + 1)'(1);

   always_ff @(posedge clk or negedge gated_nrst) begin
      if (!gated_nrst) begin
         state    <= HOLD;
         cnt      <= '0;
         idx      <= '0;
         dom_nrst <= '0;
         ready_q  <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               cnt <= '0;
               if (sync_nrst) state <= FILTER;
            end
            FILTER: begin
               if (cnt == FILT_LAST) begin
                  cnt      <= '0;
                  idx      <= '0;
                  dom_nrst <= dom_shift[NUM_DOMAINS-1:0];
                  if (NUM_DOMAINS == 1) begin
                     state   <= RUN;
                     ready_q <= 1'b1;
                  end else begin
                     state   <= STAGGER;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STAGGER: begin
               if (cnt == STAG_LAST) begin
                  cnt      <= '0;
                  idx      <= idx_nxt[IW-1:0];
                  dom_nrst <= dom_shift[NUM_DOMAINS-1:0];
                  if (idx_nxt == LAST_DOM) begin
                     state   <= RUN;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN:     ;
            default: state <= HOLD;
         endcase
      end
   end

   // ready_q clears asynchronously, so the pins go safe without a clock edge.
   assign bus.gpio_out    = ready_q ? bus.core_out : '0;
   assign bus.gpio_oeb    = ready_q ? bus.core_oeb : '1;
   assign bus.domain_nrst = dom_nrst;
   assign bus.ready       = ready_q;
   assign bus.seq_state   = state;
endmodule
